// File: rtl/if_id_hazard_ctrl.sv
// Front-end hazard sequencer: load-use stall, taken-branch flush and fetch-wait control of PC and IF/ID, ID/EX.
// Optional performance counters are built only when IF_ID_PERF_CNT_EN is defined.
module if_id_hazard_ctrl #(
    parameter int STALL_CYCLES = 2,
    parameter int FLUSH_CYCLES = 2,
    parameter int REG_W        = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             branch_taken,
    input  logic             imem_ready,
    output logic             pc_en,
    output logic             pc_redirect,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic [31:0]      stall_count,
    output logic [31:0]      flush_count,
    output logic [1:0]       state_dbg
);

    // state | meaning
    // RUN   | normal issue          STALL | load-use hold in progress
    // FLUSH | post-branch NOP fill  IWAIT | instruction fetch pending
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2,
        IWAIT = 2'd3
    } state_t;

    localparam logic [3:0] STALL_LOAD = (STALL_CYCLES > 1) ? 4'(STALL_CYCLES - 2) : 4'd0;
    localparam logic [3:0] FLUSH_LOAD = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic       hz;

    assign hz = ex_memread && (ex_rt != '0) &&
                ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_comb begin
        pc_en        = 1'b0;
        pc_redirect  = 1'b0;
        if_id_en     = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        state_nxt    = state;
        cnt_nxt      = cnt;
        if (rst) begin
            if_id_en     = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            state_nxt    = RUN;
            cnt_nxt      = 4'd0;
        end else begin
            case (state)
                STALL: begin
                    id_ex_bubble = 1'b1;
                    if (cnt == 4'd0) state_nxt = RUN;
                    else             cnt_nxt   = cnt - 4'd1;
                end
                FLUSH: begin
                    pc_en       = imem_ready;
                    if_id_en    = 1'b1;
                    if_id_flush = 1'b1;
                    if (cnt == 4'd0) state_nxt = RUN;
                    else             cnt_nxt   = cnt - 4'd1;
                end
                default: begin
                    // RUN and IWAIT share the same priority decode
                    if (hz) begin
                        id_ex_bubble = 1'b1;
                        if (STALL_CYCLES > 1) begin
                            state_nxt = STALL;
                            cnt_nxt   = STALL_LOAD;
                        end else begin
                            state_nxt = RUN;
                        end
                    end else if (branch_taken) begin
                        pc_en       = 1'b1;
                        pc_redirect = 1'b1;
                        if_id_en    = 1'b1;
                        if_id_flush = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_nxt = FLUSH;
                            cnt_nxt   = FLUSH_LOAD;
                        end else begin
                            state_nxt = RUN;
                        end
                    end else if (!imem_ready) begin
                        if_id_en    = 1'b1;
                        if_id_flush = 1'b1;
                        state_nxt   = IWAIT;
                    end else begin
                        pc_en     = 1'b1;
                        if_id_en  = 1'b1;
                        state_nxt = RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign state_dbg = state;

`ifdef IF_ID_PERF_CNT_EN
    logic        stall_evt;
    logic        flush_evt;
    logic [31:0] stall_q;
    logic [31:0] flush_q;

    // Reset also raises bubble/flush, so it is excluded from both events
    assign stall_evt = id_ex_bubble && !rst;
    assign flush_evt = if_id_flush && !rst && (pc_redirect || (state == FLUSH));

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_evt && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
            if (flush_evt && (flush_q != 32'hFFFF_FFFF)) flush_q <= flush_q + 32'd1;
        end
    end

    assign stall_count = stall_q;
    assign flush_count = flush_q;
`else
    assign stall_count = 32'd0;
    assign flush_count = 32'd0;
`endif

endmodule

// File: doc/if_id_hazard_ctrl.md
Name: if_id_hazard_ctrl

Overview:
- Pipeline front-end sequencer for the five-stage core.
- Drives the write-enable and flush of the IF/ID latch, the PC enable and redirect, and the ID/EX bubble insert.
- Detects load-use hazards, taken branches from ID, and instruction-memory wait. It sequences multi-cycle stall and flush windows with an FSM and a duration counter.

Parameters:
- STALL_CYCLES, 2, total cycles a load-use stall holds the front end, including the detection cycle (1..15).
- FLUSH_CYCLES, 2, total cycles IF/ID is flushed after a taken branch, including the detection cycle (1..15).
- REG_W, 5, register-specifier width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- id_rs  in  REG_W  rs field of the instruction in ID.
- id_rt  in  REG_W  rt field of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_memread  in  1  instruction in EX is a load.
- ex_rt  in  REG_W  destination register of the EX load.
- branch_taken  in  1  branch/jump in ID resolved taken this cycle.
- imem_ready  in  1  instruction fetch completes this cycle.
- pc_en  out  1  PC register update enable.
- pc_redirect  out  1  PC loads the branch target instead of npc.
- if_id_en  out  1  IF/ID latch write enable.
- if_id_flush  out  1  IF/ID loads a NOP (32'h0) instead of the fetched instruction.
- id_ex_bubble  out  1  ID/EX loads a NOP/control-zero.
- stall_count  out  32  load-use stall cycles (optional feature).
- flush_count  out  32  flush cycles (optional feature).
- state_dbg  out  2  current FSM state.

Behaviour:
- Clocking and reset:
  - Single clock domain; all state updates on posedge clk.
  - Outputs are a combinational decode of state, counter and current inputs (Mealy).
- Hazard term: hz = ex_memread && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt)).
- States:
  - RUN = 0, STALL = 1, FLUSH = 2, IWAIT = 3.
  - 4-bit down-counter cnt.
- Reset:
  - While rst = 1, outputs are pc_en=0, pc_redirect=0, if_id_en=1, if_id_flush=1, id_ex_bubble=1.
  - Next state is RUN, cnt=0, counters cleared.
  - Reset asserted mid-STALL or mid-FLUSH aborts the window immediately.
- RUN, evaluated in priority order hz > branch_taken > !imem_ready:
  - hz: pc_en=0, if_id_en=0, id_ex_bubble=1. If STALL_CYCLES > 1, go to STALL with cnt = STALL_CYCLES-2; otherwise stay in RUN.
  - branch_taken (no hz): pc_en=1, pc_redirect=1, if_id_en=1, if_id_flush=1. If FLUSH_CYCLES > 1, go to FLUSH with cnt = FLUSH_CYCLES-2.
  - !imem_ready: pc_en=0, if_id_en=1, if_id_flush=1. Go to IWAIT; the ID instruction proceeds.
  - Otherwise: pc_en=1, if_id_en=1, all other outputs 0.
- STALL:
  - Outputs identical to the RUN hz case.
  - branch_taken and imem_ready are ignored, because ID is held and the branch is re-evaluated after the stall.
  - If cnt == 0, go to RUN; else decrement cnt.
  - Total stall is exactly STALL_CYCLES cycles.
- FLUSH:
  - pc_en=imem_ready, pc_redirect=0, if_id_en=1, if_id_flush=1, id_ex_bubble=0.
  - hz and branch_taken are ignored, because ID holds a NOP.
  - If cnt == 0, go to RUN; else decrement.
- IWAIT:
  - Evaluated exactly as RUN, with the same priorities and the same next-state rules.
  - The "otherwise" case (imem_ready=1, no event) returns to RUN.
  - !imem_ready stays in IWAIT.
- Invariants:
  - pc_redirect implies pc_en.
  - if_id_en=0 implies if_id_flush=0.
  - id_ex_bubble=1 only in the hz/STALL cases or reset.
- ex_rt == 0 never stalls.

Optional Feature:
- Macro: IF_ID_PERF_CNT_EN.
- Defined:
  - stall_count increments on every cycle with id_ex_bubble=1 due to hz/STALL.
  - flush_count increments on every cycle with if_id_flush=1 due to a branch or FLUSH.
  - Both saturate at 32'hFFFF_FFFF and clear on rst.
- Undefined: both ports are tied to 0 and no counter flops exist.

Test Plan:
- Load-use stall: ex_memread=1, ex_rt=5, id_rs=5, imem_ready=1, default parameters → pc_en=0, if_id_en=0, id_ex_bubble=1 for exactly 2 cycles; state_dbg 0→1→0; stall_count=2.
- Zero register: ex_memread=1, ex_rt=0, id_rs=0 → no stall; pc_en=1, if_id_en=1 every cycle.
- Taken branch: branch_taken=1 for one cycle → cycle 0 has pc_redirect=1, if_id_flush=1; cycle 1 is FLUSH with if_id_flush=1, pc_redirect=0; cycle 2 is RUN; flush_count=2.
- Simultaneous events: hz=1 and branch_taken=1 in the same cycle → stall wins, pc_redirect=0 for the whole window; after return to RUN, branch_taken=1 gives pc_redirect=1.
- Fetch wait: imem_ready=0 for 3 cycles → pc_en=0, if_id_flush=1 for 3 cycles; branch_taken=1 on the 2nd cycle gives pc_redirect=1 and then FLUSH.
- Reset mid-stall: rst=1 during the 2nd STALL cycle → same cycle shows reset outputs (if_id_flush=1, id_ex_bubble=1, pc_en=0); next cycle is RUN with counters at 0.
